conv_engine_param: RTL and testbench

Parametrised 2-D convolution engine: a K x K signed kernel slides over an H x W image held in external synchronous RAM, with a configurable stride. Each output pixel passes through an arithmetic shift, optional ReLU and saturation. Results stream out on a valid/ready handshake with row/column tags. Replaces the fixed 3x3, 8-bit, fire-and-forget conv block in the conv_layer datapath.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_mac.sv | 28 ++
 rtl/conv_engine_param.sv | 167 ++++++++++++++++
 tb/tb_conv_engine_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the parametrised convolution engine:
// FSM state encoding, width helpers and the shift/ReLU/saturate output stage.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, ACC, OUT, DONE} state_t;

    // Ceiling log2, never below 1 so it can size a port directly.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    localparam int OH = out_dim(28, 3, 1);
    localparam int OW = out_dim(28, 3, 1);

    function automatic logic signed [63:0] sat_shift_relu(input logic signed [63:0] acc,
                                                          input int shift,
                                                          input logic relu,
                                                          input int dw);
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = acc >>> shift;
        if (relu && (y < 0)) y = '0;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (y > hi)      y = hi;
        else if (y < lo) y = lo;
        return y;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed DW x DW multiply-accumulate; acc shows the running sum including the
// product absorbed this cycle when en is high. No backpressure.
module conv_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod = a * b;
    assign acc    = r_acc + (en ? ACCW'(w_prod) : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     r_acc <= '0;
        else if (clr) r_acc <= '0;
        else if (en)  r_acc <= acc;
    end

endmodule

// File: rtl/conv_engine_param.sv
// K x K strided convolution over an external synchronous RAM; K*K+2 cycles per
// output pixel with out_ready high; results hold stable while out_ready is low.
module conv_engine_param
    import conv_pkg::*;
#(
    parameter int H      = 28,
    parameter int W      = 28,
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int STRIDE = 1,
    parameter int ACCW   = 20,
    parameter int SHIFT  = 0,
    parameter int AW     = 10,
    localparam int N_OH  = out_dim(H, K, STRIDE),
    localparam int N_OW  = out_dim(W, K, STRIDE),
    localparam int RW    = clog2(N_OH),
    localparam int CW    = clog2(N_OW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic [K*K*DW-1:0]      kernel,
    output logic [AW-1:0]          mem_addr,
    input  logic signed [DW-1:0]   mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW-1:0]   out_data,
    output logic [RW-1:0]          out_row,
    output logic [CW-1:0]          out_col,
    output logic                   busy,
    output logic                   done
);

    localparam int KW = clog2(K);
    localparam int TW = clog2(K * K);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [RW-1:0] R_LAST = RW'(N_OH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_OW - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [K*K*DW-1:0]      r_kernel;
    logic                   r_relu;
    logic [RW-1:0]          r_row;
    logic [CW-1:0]          r_col;
    logic [KW-1:0]          r_ki;
    logic [KW-1:0]          r_kj;
    logic [AW-1:0]          r_addr;
    logic [AW-1:0]          w_addr;
    logic [TW-1:0]          r_cap_idx;
    logic                   r_cap_vld;
    logic signed [DW-1:0]   r_out_data;
    logic signed [DW-1:0]   w_tap_wt;
    logic signed [DW-1:0]   w_y;
    logic signed [ACCW-1:0] w_acc;
    logic                   w_hs;
    logic                   w_last_tap;
    logic                   w_last_pix;
    logic                   w_mac_clr;
    logic                   w_mac_en;

    assign w_last_tap = (r_ki == K_LAST) && (r_kj == K_LAST);
    assign w_last_pix = (r_row == R_LAST) && (r_col == C_LAST);
    assign w_hs       = (r_state == OUT) && out_ready;
    assign w_addr     = AW'((int'(r_row) * STRIDE + int'(r_ki)) * W
                            + int'(r_col) * STRIDE + int'(r_kj));
    // The weight follows the tap issued one cycle earlier, matching RAM latency.
    assign w_tap_wt   = r_kernel[r_cap_idx*DW +: DW];
    // In ACC the mac output already includes the last product.
    assign w_y        = DW'(sat_shift_relu(64'(w_acc), SHIFT, r_relu, DW));

    assign mem_addr = (r_state == FETCH) ? w_addr : r_addr;
    assign out_data = r_out_data;
    assign out_row  = r_row;
    assign out_col  = r_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (w_last_tap) w_next = ACC;
            ACC:     w_next = OUT;
            OUT:     if (w_hs) w_next = w_last_pix ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == FETCH) || (r_state == ACC) || (r_state == OUT);
        done      = (r_state == DONE);
        out_valid = (r_state == OUT);
        w_mac_clr = ((r_state == IDLE) && start) || w_hs;
        w_mac_en  = r_cap_vld;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kernel   <= '0;
            r_relu     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_ki       <= '0;
            r_kj       <= '0;
            r_addr     <= '0;
            r_cap_idx  <= '0;
            r_cap_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_cap_vld <= (r_state == FETCH);
            r_cap_idx <= TW'(int'(r_ki) * K + int'(r_kj));
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_kernel <= kernel;
                        r_relu   <= relu_en;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_ki     <= '0;
                        r_kj     <= '0;
                    end
                end
                FETCH: begin
                    r_addr <= w_addr;
                    if (r_kj == K_LAST) begin
                        r_kj <= '0;
                        r_ki <= w_last_tap ? '0 : r_ki + 1'b1;
                    end else begin
                        r_kj <= r_kj + 1'b1;
                    end
                end
                ACC: r_out_data <= w_y;
                OUT: begin
                    if (w_hs && !w_last_pix) begin
                        if (r_col == C_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    conv_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_mac_clr),
        .en  (w_mac_en),
        .a   (mem_rdata),
        .b   (w_tap_wt),
        .acc (w_acc)
    );

endmodule

// File: tb/tb_conv_engine_param.sv
// Bench for conv_engine_param: a stride-1 and a stride-2 instance share one
// image RAM model; every handshake is checked against a direct convolution.
module tb_conv_engine_param;

    localparam int H = 28, W = 28, K = 3, DW = 8, AW = 10;
    localparam int OW1 = 26, OW2 = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           start_s;
    logic                 relu_in;
    logic [K*K*DW-1:0]    kern_in;
    logic                 out_ready;
    logic [AW-1:0]        addr1, addr2;
    logic signed [DW-1:0] rdata1, rdata2, data1, data2;
    logic [1:0]           valid_s, busy_s, done_s;
    logic [4:0]           row1, col1;
    logic [3:0]           row2, col2;

    logic signed [DW-1:0] img [H*W];
    logic signed [DW-1:0] kw  [K*K];
    logic                 relu_m;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt [2];
    int done_cnt [2];
    int first_dat [2];
    int idx1, idx2;
    bit bp_en;
    bit stall1, chk_addr1, chk_addr2;
    logic [4:0]           snap_r1, snap_c1;
    logic signed [DW-1:0] snap_d1;

    conv_engine_param #(.H(H), .W(W), .K(K), .DW(DW), .STRIDE(1), .ACCW(20), .SHIFT(0), .AW(AW)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .relu_en(relu_in), .kernel(kern_in),
        .mem_addr(addr1), .mem_rdata(rdata1), .out_valid(valid_s[0]), .out_ready(out_ready),
        .out_data(data1), .out_row(row1), .out_col(col1), .busy(busy_s[0]), .done(done_s[0]));

    conv_engine_param #(.H(H), .W(W), .K(K), .DW(DW), .STRIDE(2), .ACCW(20), .SHIFT(0), .AW(AW)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .relu_en(relu_in), .kernel(kern_in),
        .mem_addr(addr2), .mem_rdata(rdata2), .out_valid(valid_s[1]), .out_ready(out_ready),
        .out_data(data2), .out_row(row2), .out_col(col2), .busy(busy_s[1]), .done(done_s[1]));

    always @(posedge clk) begin
        rdata1 <= img[addr1];
        rdata2 <= img[addr2];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Direct valid-mode convolution, ReLU and 8-bit saturation (shift is 0).
    function automatic int model_pix(input int s, input int r, input int c);
        int acc;
        acc = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                acc += int'(img[(r*s + i)*W + c*s + j]) * int'(kw[i*K + j]);
        if (relu_m && acc < 0) acc = 0;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    function automatic int tag(input int r, input int c, input int d);
        return (r << 16) | (c << 8) | (d & 255);
    endfunction

    task automatic set_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r*W + c] = DW'((r*W + c) % 128);
                    1:       img[r*W + c] = DW'(r);
                    2:       img[r*W + c] = DW'(c);
                    3:       img[r*W + c] = 8'sd127;
                    default: img[r*W + c] = 8'h80;
                endcase
    endtask

    task automatic set_kern(input int k0, input int k1, input int k2, input int k3, input int k4,
                            input int k5, input int k6, input int k7, input int k8, input bit relu);
        kw[0] = DW'(k0); kw[1] = DW'(k1); kw[2] = DW'(k2);
        kw[3] = DW'(k3); kw[4] = DW'(k4); kw[5] = DW'(k5);
        kw[6] = DW'(k6); kw[7] = DW'(k7); kw[8] = DW'(k8);
        for (int t = 0; t < K*K; t++) kern_in[t*DW +: DW] = kw[t];
        relu_in = relu;
        relu_m  = relu;
    endtask

    // Stride-1 instance: every handshake, tap-0 address and stall stability.
    always @(negedge clk) begin
        if (stall1)
            check("hold_stable", {valid_s[0], row1, col1, data1}, {1'b1, snap_r1, snap_c1, snap_d1});
        stall1  = valid_s[0] && !out_ready;
        snap_r1 = row1;
        snap_c1 = col1;
        snap_d1 = data1;
        if (chk_addr1 && busy_s[0])
            check("tap0_addr_s1", addr1, (hs_cnt[0] / OW1) * W + (hs_cnt[0] % OW1));
        chk_addr1 = 0;
        if (valid_s[0] && out_ready) begin
            idx1 = hs_cnt[0];
            check("pixel_s1", tag(row1, col1, data1),
                  tag(idx1 / OW1, idx1 % OW1, model_pix(1, idx1 / OW1, idx1 % OW1)));
            if (idx1 == 0) first_dat[0] = data1;
            hs_cnt[0]++;
            chk_addr1 = 1;
        end
        if (done_s[0]) done_cnt[0]++;
    end

    // Stride-2 instance.
    always @(negedge clk) begin
        if (chk_addr2 && busy_s[1]) begin
            check("tap0_addr_s2", addr2, (hs_cnt[1] / OW2) * 2 * W + (hs_cnt[1] % OW2) * 2);
            if (hs_cnt[1] == 14) check("tap0_addr_out_1_1", addr2, 58);
        end
        chk_addr2 = 0;
        if (valid_s[1] && out_ready) begin
            idx2 = hs_cnt[1];
            check("pixel_s2", tag(row2, col2, data2),
                  tag(idx2 / OW2, idx2 % OW2, model_pix(2, idx2 / OW2, idx2 % OW2)));
            if (idx2 == 0) first_dat[1] = data2;
            hs_cnt[1]++;
            chk_addr2 = 1;
        end
        if (done_s[1]) done_cnt[1]++;
    end

    // Consumer stall: hold out_ready low for 5 edges while output 3 is presented.
    always @(posedge clk) begin
        #1;
        if (bp_en && valid_s[0] && hs_cnt[0] == 3) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            bp_en     = 1'b0;
        end
    end

    task automatic run_frame(input int d, input int exp_cyc, input int exp_hs, input bit mid_start,
                             input int exp_first, input string name);
        int cyc;
        check({name, "_model_pin"}, model_pix(d + 1, 0, 0), exp_first);
        @(negedge clk);
        hs_cnt[d]    = 0;
        done_cnt[d]  = 0;
        first_dat[d] = 999;
        start_s[d]   = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        check({name, "_busy"}, busy_s[d], 1);
        cyc = 0;
        while (!done_s[d] && cyc < 20000) begin
            if (mid_start && cyc == 100) begin
                start_s[d] = 1'b1;
                kern_in    = ~kern_in;
                relu_in    = ~relu_in;
            end
            if (cyc == 101) start_s[d] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, "_cycles"}, cyc, exp_cyc);
        repeat (3) @(negedge clk);
        check({name, "_handshakes"}, hs_cnt[d], exp_hs);
        check({name, "_done_pulses"}, done_cnt[d], 1);
        check({name, "_first_out"}, first_dat[d], exp_first);
        check({name, "_idle"}, busy_s[d], 0);
    endtask

    initial begin
        rst       = 1'b0;
        start_s   = '0;
        kern_in   = '0;
        relu_in   = 1'b0;
        relu_m    = 1'b0;
        out_ready = 1'b1;
        bp_en     = 1'b0;
        set_img(0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {addr1, data1, row1, col1, valid_s[0], busy_s[0], done_s[0]}, 0);
        rst = 1'b1;
        @(negedge clk);

        set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_frame(0, 7436, 676, 0, 29, "identity");

        set_img(1);
        set_kern(1, 2, 1, 0, 0, 0, -1, -2, -1, 0);
        run_frame(0, 7436, 676, 1, -8, "sobel_rows");
        set_img(2);
        set_kern(1, 2, 1, 0, 0, 0, -1, -2, -1, 0);
        run_frame(0, 7436, 676, 0, 0, "sobel_cols");
        set_img(1);
        set_kern(1, 2, 1, 0, 0, 0, -1, -2, -1, 1);
        run_frame(0, 7436, 676, 0, 0, "sobel_relu");

        set_img(3);
        set_kern(127, 127, 127, 127, 127, 127, 127, 127, 127, 0);
        run_frame(0, 7436, 676, 0, 127, "sat_pos");
        set_img(4);
        run_frame(0, 7436, 676, 0, -128, "sat_neg");

        set_img(0);
        set_kern(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        bp_en = 1'b1;
        run_frame(0, 7441, 676, 0, 29, "backpressure");

        @(negedge clk);
        hs_cnt[0]  = 0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_midrun", {addr1, data1, row1, col1, valid_s[0], busy_s[0], done_s[0]}, 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(0, 7436, 676, 0, 29, "after_reset");

        run_frame(1, 1859, 169, 1, 29, "stride2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
